// File: rtl/capture_dump_pkg.sv
// capture_dump_pkg: shared FSM states, header sync bytes and sizing helper (HDR state and sync bytes exist only with CAPTURE_DUMP_HEADER_EN)
package capture_dump_pkg;
`ifdef CAPTURE_DUMP_HEADER_EN
  typedef enum logic [2:0] {IDLE, CAPTURE, DUMP, DONE, HDR} state_t;
  localparam state_t DUMP_ENTRY = HDR;
  localparam logic [7:0] SYNC0 = 8'hA5;
  localparam logic [7:0] SYNC1 = 8'h5A;
`else
  typedef enum logic [1:0] {IDLE, CAPTURE, DUMP, DONE} state_t;
  localparam state_t DUMP_ENTRY = DUMP;
`endif
  function automatic int calc_bytes_per_samp(input int w);
    return (w + 7) / 8;
  endfunction
endpackage

// File: rtl/capture_dump_ctrl_sample_buf.sv
// sample_buf: simple dual-port RAM, one write port, one registered read port
module sample_buf #(
  parameter int W = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);
  logic [W-1:0] mem [DEPTH];
  // write on we, read with one cycle latency
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/capture_dump_ctrl.sv
// capture_dump_ctrl: capture DEPTH decimated frames, then stream them as bytes (CAPTURE_DUMP_HEADER_EN prepends a 6-byte header)
module capture_dump_ctrl
  import capture_dump_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int SAMPLE_W = 16,
  parameter int DEPTH = 4096,
  parameter int DECIM_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       arm,
  input  logic                       continuous,
  input  logic [DECIM_W-1:0]         decim,
  input  logic                       in_valid,
  input  logic [NUM_CH*SAMPLE_W-1:0] in_data,
  output logic [7:0]                 tx_data,
  output logic                       tx_valid,
  input  logic                       tx_ready,
  output logic                       busy,
  output logic                       done,
  output logic                       overrun
);
  localparam int BYTES_PER_SAMP = calc_bytes_per_samp(SAMPLE_W);
  localparam int AW = $clog2(DEPTH);
  localparam int TOTAL_BYTES = DEPTH * NUM_CH * BYTES_PER_SAMP;
  localparam int EW = BYTES_PER_SAMP * 8;
  localparam int NW = $clog2(TOTAL_BYTES);
  localparam int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  localparam int BIW = BYTES_PER_SAMP > 1 ? $clog2(BYTES_PER_SAMP) : 1;
  state_t state, state_d;
  logic [AW-1:0] frame_cnt, fr;
  logic [DECIM_W-1:0] decim_cnt, decim_q;
  logic [CW-1:0] ch;
  logic [BIW-1:0] bi;
  logic [NW-1:0] sent;
  logic rd_ok, src_done, wr_en, load, acc, frame_end, start, dump_ph;
  logic [NUM_CH*SAMPLE_W-1:0] rdata;
  logic signed [SAMPLE_W-1:0] samp;
  logic signed [EW-1:0] ext;
  logic [7:0] dump_byte;
`ifdef CAPTURE_DUMP_HEADER_EN
  logic [2:0] hdr_cnt;
  logic hdr_load;
  logic [7:0] hdr_byte;
`endif
  sample_buf #(.W(NUM_CH * SAMPLE_W), .DEPTH(DEPTH)) u_buf (
    .clk   (clk),
    .we    (wr_en),
    .waddr (frame_cnt),
    .wdata (in_data),
    .raddr (fr),
    .rdata (rdata)
  );
  assign busy = state != IDLE;
  assign done = state == DONE;
  // next state, capture write strobe and byte selection from the current read word
  always_comb begin
    start = (state == IDLE && arm) || (state == DONE && continuous);
    wr_en = state == CAPTURE && in_valid && decim_cnt == '0;
    acc = tx_valid && tx_ready;
    load = state == DUMP && rd_ok && !src_done && (!tx_valid || tx_ready);
    frame_end = load && bi == BIW'(BYTES_PER_SAMP - 1) && ch == CW'(NUM_CH - 1);
    samp = rdata[ch*SAMPLE_W +: SAMPLE_W];
    ext = EW'(samp);
    dump_byte = ext[(BYTES_PER_SAMP - 1 - bi)*8 +: 8];
`ifdef CAPTURE_DUMP_HEADER_EN
    dump_ph = state == DUMP || state == HDR;
    hdr_load = state == HDR && (!tx_valid || tx_ready);
    hdr_byte = hdr_cnt == 3'd0 ? SYNC0 : hdr_cnt == 3'd1 ? SYNC1 : hdr_cnt == 3'd2 ? 8'(NUM_CH)
             : hdr_cnt == 3'd3 ? 8'(BYTES_PER_SAMP) : hdr_cnt == 3'd4 ? 8'(DEPTH >> 8) : 8'(DEPTH);
`else
    dump_ph = state == DUMP;
`endif
    state_d = start ? CAPTURE
            : state == CAPTURE && wr_en && frame_cnt == AW'(DEPTH - 1) ? DUMP_ENTRY
            : state == DUMP && acc && src_done ? DONE
            : state == DONE ? IDLE
            : state;
`ifdef CAPTURE_DUMP_HEADER_EN
    if (hdr_load && hdr_cnt == 3'd5) state_d = DUMP;
`endif
  end
  // state, capture counters, read pointer and registered byte output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      frame_cnt <= '0;
      decim_cnt <= '0;
      decim_q <= '0;
      fr <= '0;
      ch <= '0;
      bi <= '0;
      sent <= '0;
      rd_ok <= 1'b0;
      src_done <= 1'b0;
      tx_valid <= 1'b0;
      tx_data <= '0;
      overrun <= 1'b0;
`ifdef CAPTURE_DUMP_HEADER_EN
      hdr_cnt <= '0;
`endif
    end else begin
      state <= state_d;
      if (start) begin
        frame_cnt <= '0;
        decim_cnt <= '0;
        decim_q <= decim;
        fr <= '0;
        ch <= '0;
        bi <= '0;
        sent <= '0;
        src_done <= 1'b0;
`ifdef CAPTURE_DUMP_HEADER_EN
        hdr_cnt <= '0;
`endif
      end else if (state == CAPTURE && in_valid) begin
        decim_cnt <= decim_cnt == decim_q ? '0 : decim_cnt + 1'b1;
        if (wr_en) frame_cnt <= frame_cnt + 1'b1;
      end
      rd_ok <= state != CAPTURE && !frame_end;
      if (load) begin
        tx_data <= dump_byte;
        tx_valid <= 1'b1;
        sent <= sent + 1'b1;
        src_done <= sent == NW'(TOTAL_BYTES - 1);
        bi <= bi == BIW'(BYTES_PER_SAMP - 1) ? '0 : bi + 1'b1;
        if (bi == BIW'(BYTES_PER_SAMP - 1)) ch <= ch == CW'(NUM_CH - 1) ? '0 : ch + 1'b1;
        if (frame_end) fr <= fr + 1'b1;
      end
`ifdef CAPTURE_DUMP_HEADER_EN
      else if (hdr_load) begin
        tx_data <= hdr_byte;
        tx_valid <= 1'b1;
        hdr_cnt <= hdr_cnt + 1'b1;
      end
`endif
      else if (acc) tx_valid <= 1'b0;
      if (state == IDLE && arm) overrun <= 1'b0;
      else if (dump_ph && in_valid && continuous) overrun <= 1'b1;
    end
  end
endmodule

// File: tb/tb_capture_dump_ctrl.sv
// tb_capture_dump_ctrl: table vectors and scoreboard for capture_dump_ctrl (honours CAPTURE_DUMP_HEADER_EN)
module tb_capture_dump_ctrl;
`ifdef CAPTURE_DUMP_HEADER_EN
  localparam int NB = 38;
`else
  localparam int NB = 32;
`endif
  typedef struct {
    logic [11:0] c0;
    logic [11:0] c1;
    logic [31:0] bytes;
  } vec_t;
  logic clk, rst, arm, continuous, in_valid, tx_valid, tx_ready, busy, done, overrun;
  logic [7:0] decim, tx_data;
  logic [23:0] in_data;
  logic [7:0] exp_q[$];
  vec_t tbl[8];
  int checks, errors, acc_cnt, done_cnt;
  bit rand_rdy, stall_prev;
  logic [7:0] stall_data;
  capture_dump_ctrl #(.NUM_CH(2), .SAMPLE_W(12), .DEPTH(8), .DECIM_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .arm        (arm),
    .continuous (continuous),
    .decim      (decim),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .done       (done),
    .overrun    (overrun)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [23:0] mkf(int v);
    logic [11:0] a, b;
    a = 12'(v * 37);
    b = 12'(-v * 11);
    return {b, a};
  endfunction
  task automatic push_frame(logic [23:0] f);
    logic [11:0] a, b;
    a = f[11:0];
    b = f[23:12];
    exp_q.push_back({{4{a[11]}}, a[11:8]});
    exp_q.push_back(a[7:0]);
    exp_q.push_back({{4{b[11]}}, b[11:8]});
    exp_q.push_back(b[7:0]);
  endtask
  task automatic push_hdr();
`ifdef CAPTURE_DUMP_HEADER_EN
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'h02);
    exp_q.push_back(8'h02);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h08);
`endif
  endtask
  task automatic mon();
    logic [7:0] e;
    if (rst) begin
      stall_prev = 1'b0;
      return;
    end
    if (stall_prev) chk("hold_while_stalled", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, stall_data});
    stall_prev = tx_valid && !tx_ready;
    stall_data = tx_data;
    if (tx_valid && tx_ready) begin
      acc_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL extra_byte: got %0h expected no byte", tx_data);
      end else begin
        e = exp_q.pop_front();
        chk("byte", 32'(tx_data), 32'(e));
      end
    end
    if (done) begin
      done_cnt++;
      chk("done_after_last", exp_q.size(), 0);
    end
  endtask
  task automatic tick();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
    if (rand_rdy) tx_ready = $urandom_range(0, 9) < 3;
  endtask
  task automatic arm_go();
    push_hdr();
    arm = 1'b1;
    tick();
    arm = 1'b0;
    chk("busy_after_arm", busy, 1);
  endtask
  task automatic wait_done(int budget);
    int d0, n;
    d0 = done_cnt;
    n = 0;
    while (done_cnt == d0 && n < budget) begin
      tick();
      n++;
    end
    chk("done_seen", done_cnt != d0, 1);
  endtask
  task automatic drive_table();
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data = {tbl[i].c1, tbl[i].c0};
      for (int k = 3; k >= 0; k--) exp_q.push_back(tbl[i].bytes[k*8 +: 8]);
      tick();
    end
    in_valid = 1'b0;
  endtask
  task automatic run_table(int budget);
    int a0, d0;
    a0 = acc_cnt;
    d0 = done_cnt;
    arm_go();
    drive_table();
    tick();
    tick();
    chk("first_valid_latency", tx_valid, 1);
    wait_done(budget);
    repeat (3) tick();
    chk("byte_count", acc_cnt - a0, NB);
    chk("done_pulses", done_cnt - d0, 1);
    chk("idle_after_done", busy, 0);
  endtask
  initial begin
    int v, d_seen, dumps, a0, n;
    tbl[0] = '{12'h000, 12'h000, 32'h0000_0000};
    tbl[1] = '{12'h001, 12'hFFF, 32'h0001_FFFF};
    tbl[2] = '{12'h7FF, 12'h800, 32'h07FF_F800};
    tbl[3] = '{12'h123, 12'h9AB, 32'h0123_F9AB};
    tbl[4] = '{12'h400, 12'hC00, 32'h0400_FC00};
    tbl[5] = '{12'h0FF, 12'hF01, 32'h00FF_FF01};
    tbl[6] = '{12'h555, 12'hAAA, 32'h0555_FAAA};
    tbl[7] = '{12'h7FE, 12'h801, 32'h07FE_F801};
    rst = 1'b1;
    arm = 1'b0;
    continuous = 1'b0;
    decim = '0;
    in_valid = 1'b0;
    in_data = '0;
    tx_ready = 1'b1;
    rand_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_overrun", overrun, 0);
    rst = 1'b0;
    tick();
    run_table(300);
    decim = 8'd2;
    arm_go();
    decim = 8'd5;
    for (int k = 0; k < 24; k++) begin
      in_valid = 1'b1;
      in_data = mkf(k);
      if (k % 3 == 0) push_frame(mkf(k));
      tick();
    end
    in_valid = 1'b0;
    chk("dump_entry_after_22nd", tx_valid, 1);
    wait_done(300);
    chk("no_overrun_oneshot", overrun, 0);
    decim = '0;
    tick();
    rand_rdy = 1'b1;
    run_table(1500);
    rand_rdy = 1'b0;
    tx_ready = 1'b1;
    tick();
    continuous = 1'b1;
    v = 0;
    arm_go();
    for (int k = 0; k < 8; k++) push_frame(mkf(v + k));
    d_seen = done_cnt;
    dumps = 0;
    for (int c = 0; c < 600; c++) begin
      if (done_cnt != d_seen) begin
        d_seen = done_cnt;
        dumps++;
        if (dumps == 1) begin
          chk("overrun_set", overrun, 1);
          continuous = 1'b0;
          push_hdr();
          for (int k = 0; k < 8; k++) push_frame(mkf(v + k));
        end
      end
      if (dumps == 2) break;
      in_valid = 1'b1;
      in_data = mkf(v);
      tick();
      v++;
    end
    in_valid = 1'b0;
    chk("two_dumps", dumps, 2);
    chk("idle_after_cont", busy, 0);
    tick();
    tick();
    chk("overrun_sticky", overrun, 1);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    chk("overrun_cleared", overrun, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    arm_go();
    drive_table();
    a0 = acc_cnt;
    n = 0;
    while (acc_cnt - a0 < 10 && n < 300) begin
      tick();
      n++;
    end
    chk("reach_byte10", acc_cnt - a0, 10);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_tx_valid", tx_valid, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_done", done, 0);
    exp_q.delete();
    tick();
    rst = 1'b0;
    tick();
    run_table(300);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
